// File: rtl/rps_pkg.sv
// Shared types and constants for the rock/paper/scissors choice capture path.
// Choices are one-hot; NONE is the hidden/unlocked encoding.
package rps_pkg;

    typedef logic [2:0] choice_t;

    localparam choice_t NONE     = 3'b000;
    localparam choice_t ROCK     = 3'b001;
    localparam choice_t PAPER    = 3'b010;
    localparam choice_t SCISSORS = 3'b100;

    typedef enum logic {
        WAIT   = 1'b0,
        REVEAL = 1'b1
    } phase_t;

    // True only when exactly one button strobed this cycle.
    function automatic logic is_single(input choice_t c);
        return (c == ROCK) || (c == PAPER) || (c == SCISSORS);
    endfunction

endpackage

// File: rtl/rps_player_latch.sv
// One player's buttons: 2-flop sync, debounce, press-edge detect and a
// write-once lock of the first single-button press, cleared by round clear.
module rps_player_latch
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10400,
    parameter int CNT_W           = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       clr,
    output logic       locked,
    output logic [2:0] code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] strobe;
    logic       locked_reg;
    choice_t    code_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_prev_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    deb_reg      <= 1'b0;
                    deb_prev_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= btn[gi];
                    sync2_reg    <= sync1_reg;
                    deb_prev_reg <= deb_reg;
                    // Any return to the debounced level restarts the stability window.
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign strobe[gi] = deb_reg & ~deb_prev_reg;
        end
    endgenerate

    // Clear has priority so a press coinciding with it is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_reg <= 1'b0;
            code_reg   <= NONE;
        end else if (clr) begin
            locked_reg <= 1'b0;
            code_reg   <= NONE;
        end else if (!locked_reg && is_single(strobe)) begin
            locked_reg <= 1'b1;
            code_reg   <= strobe;
        end
    end

    assign locked = locked_reg;
    assign code   = code_reg;

endmodule

// File: rtl/rps_choice_capture.sv
// Captures both players' choices and keeps them hidden until both have
// locked, then presents the one-hot codes until the round is cleared.
module rps_choice_capture
    import rps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10400,
    parameter int CNT_W           = 14
) (
    input  logic       clk_i,
    input  logic       reset,
    input  logic [2:0] btn_p1_i,
    input  logic [2:0] btn_p2_i,
    input  logic       round_clr_i,
    output logic [2:0] p1,
    output logic [2:0] p2,
    output logic       p1_locked,
    output logic       p2_locked,
    output logic       reveal
);

    logic    lock1, lock2;
    choice_t code1, code2;
    phase_t  state_reg, state_next;
    choice_t p1_reg, p1_next;
    choice_t p2_reg, p2_next;
    logic    reveal_reg, reveal_next;

    rps_player_latch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_p1 (
        .clk   (clk_i),
        .reset (reset),
        .btn   (btn_p1_i),
        .clr   (round_clr_i),
        .locked(lock1),
        .code  (code1)
    );

    rps_player_latch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_p2 (
        .clk   (clk_i),
        .reset (reset),
        .btn   (btn_p2_i),
        .clr   (round_clr_i),
        .locked(lock2),
        .code  (code2)
    );

    // Outputs are decoded from the next state so they change with reveal.
    always_comb begin
        state_next  = state_reg;
        p1_next     = NONE;
        p2_next     = NONE;
        reveal_next = 1'b0;
        case (state_reg)
            WAIT:    if (lock1 && lock2) state_next = REVEAL;
            REVEAL:  state_next = REVEAL;
            default: state_next = WAIT;
        endcase
        if (round_clr_i) state_next = WAIT;
        if (state_next == REVEAL) begin
            p1_next     = code1;
            p2_next     = code2;
            reveal_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_reg  <= WAIT;
            p1_reg     <= NONE;
            p2_reg     <= NONE;
            reveal_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            p1_reg     <= p1_next;
            p2_reg     <= p2_next;
            reveal_reg <= reveal_next;
        end
    end

    assign p1        = p1_reg;
    assign p2        = p2_reg;
    assign p1_locked = lock1;
    assign p2_locked = lock2;
    assign reveal    = reveal_reg;

endmodule

// File: tb/tb_rps_choice_capture.sv
// Scoreboard bench for rps_choice_capture with a short debounce window.
module tb_rps_choice_capture;

    logic       clk_i = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn_p1_i = 3'b000;
    logic [2:0] btn_p2_i = 3'b000;
    logic       round_clr_i = 1'b0;
    logic [2:0] p1, p2;
    logic       p1_locked, p2_locked, reveal;

    rps_choice_capture #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk_i      (clk_i),
        .reset      (reset),
        .btn_p1_i   (btn_p1_i),
        .btn_p2_i   (btn_p2_i),
        .round_clr_i(round_clr_i),
        .p1         (p1),
        .p2         (p2),
        .p1_locked  (p1_locked),
        .p2_locked  (p2_locked),
        .reveal     (reveal)
    );

    initial forever #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [8:0] obs;
    assign obs = {p1, p2, p1_locked, p2_locked, reveal};

    typedef struct {
        string      name;
        logic [8:0] exp;
        int         at;
    } sb_t;
    sb_t sb[$];

    function automatic logic [8:0] mk(input logic [2:0] a, input logic [2:0] b,
                                      input logic l1, input logic l2, input logic r);
        return {a, b, l1, l2, r};
    endfunction

    task automatic push(input string name, input int at, input logic [8:0] exp);
        sb_t e;
        e.name = name;
        e.at   = at;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        sb_t e;
        int  k;
        reset = 1'b1;
        repeat (2) @(negedge clk_i);
        reset = 1'b0;
        k = cyc;
        push("reset_idle_a", k + 1, mk(3'b000, 3'b000, 0, 0, 0));
        push("reset_idle_b", k + 20, mk(3'b000, 3'b000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
    endtask

    task automatic test_lock_reveal();
        sb_t e;
        int  k;
        k = cyc;
        btn_p1_i = 3'b010;
        push("p1_hidden_pre", k + 6, mk(3'b000, 3'b000, 0, 0, 0));
        push("p1_lock_latency", k + 7, mk(3'b000, 3'b000, 1, 0, 0));
        push("p1_still_hidden", k + 10, mk(3'b000, 3'b000, 1, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        btn_p1_i = 3'b000;
        k = cyc;
        btn_p2_i = 3'b100;
        push("p2_lock_no_reveal", k + 7, mk(3'b000, 3'b000, 1, 1, 0));
        push("reveal_after_lock", k + 8, mk(3'b010, 3'b100, 1, 1, 1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        repeat (2) @(negedge clk_i);
        btn_p2_i = 3'b000;
        repeat (10) @(negedge clk_i);
        k = cyc;
        round_clr_i = 1'b1;
        @(negedge clk_i);
        round_clr_i = 1'b0;
        push("clear_after_reveal", k + 1, mk(3'b000, 3'b000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
    endtask

    task automatic test_bounce();
        sb_t e;
        int  k;
        for (int i = 0; i < 12; i++) begin
            btn_p1_i = (i % 2 == 0) ? 3'b001 : 3'b000;
            @(negedge clk_i);
        end
        btn_p1_i = 3'b000;
        k = cyc;
        push("bounce_a", k + 1, mk(3'b000, 3'b000, 0, 0, 0));
        push("bounce_b", k + 6, mk(3'b000, 3'b000, 0, 0, 0));
        push("bounce_c", k + 10, mk(3'b000, 3'b000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
    endtask

    task automatic test_double_press();
        sb_t e;
        int  k;
        k = cyc;
        btn_p2_i = 3'b011;
        push("p2_double_a", k + 8, mk(3'b000, 3'b000, 0, 0, 0));
        push("p2_double_b", k + 14, mk(3'b000, 3'b000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        btn_p2_i = 3'b000;
        repeat (10) @(negedge clk_i);
        k = cyc;
        btn_p2_i = 3'b001;
        push("p2_single_lock", k + 7, mk(3'b000, 3'b000, 0, 1, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        repeat (3) @(negedge clk_i);
        btn_p2_i = 3'b000;
        k = cyc;
        btn_p1_i = 3'b001;
        push("p1_rock_lock", k + 7, mk(3'b000, 3'b000, 1, 1, 0));
        push("reveal_rock_rock", k + 8, mk(3'b001, 3'b001, 1, 1, 1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        repeat (3) @(negedge clk_i);
        btn_p1_i = 3'b000;
        repeat (10) @(negedge clk_i);
    endtask

    task automatic test_locked_and_clear();
        sb_t e;
        int  k;
        k = cyc;
        btn_p1_i = 3'b100;
        push("p1_press_ignored", k + 10, mk(3'b001, 3'b001, 1, 1, 1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        k = cyc;
        round_clr_i = 1'b1;
        @(negedge clk_i);
        round_clr_i = 1'b0;
        push("round_clear", k + 1, mk(3'b000, 3'b000, 0, 0, 0));
        push("held_through_clear", k + 12, mk(3'b000, 3'b000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        btn_p1_i = 3'b000;
        repeat (10) @(negedge clk_i);
    endtask

    task automatic test_async_reset();
        sb_t e;
        int  k;
        k = cyc;
        btn_p1_i = 3'b100;
        push("p1_scissors_lock", k + 7, mk(3'b000, 3'b000, 1, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        btn_p1_i = 3'b000;
        #1 reset = 1'b1;
        #1;
        push("async_reset_no_edge", cyc, mk(3'b000, 3'b000, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        @(negedge clk_i);
        reset = 1'b0;
        k = cyc;
        btn_p1_i = 3'b010;
        push("p1_relock_after_reset", k + 7, mk(3'b000, 3'b000, 1, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        repeat (3) @(negedge clk_i);
        btn_p1_i = 3'b000;
        k = cyc;
        btn_p2_i = 3'b010;
        push("p2_lock_after_reset", k + 7, mk(3'b000, 3'b000, 1, 1, 0));
        push("reveal_after_reset", k + 8, mk(3'b010, 3'b010, 1, 1, 1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            while (cyc < e.at) @(negedge clk_i);
            checks++;
            if (obs !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.exp);
            end else $display("check %s cyc=%0d obs=%b", e.name, cyc, obs);
        end
        btn_p2_i = 3'b000;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_lock_reveal();
        test_bounce();
        test_double_press();
        test_locked_and_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got running want finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
